// File: rtl/axi_stream_extract_header_if.sv
// rtl/axi_stream_extract_header_if.sv - cfg, input, payload and header channels of the header extractor
interface axi_stream_extract_header_if #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
   logic                    valid_cfg;
   logic [BYTE_CNT_WD-1:0]  byte_strip_cnt;
   logic                    ready_cfg;

   logic                    valid_in;
   logic [DATA_WD-1:0]      data_in;
   logic [DATA_BYTE_WD-1:0] keep_in;
   logic                    last_in;
   logic                    ready_in;

   logic                    valid_out;
   logic [DATA_WD-1:0]      data_out;
   logic [DATA_BYTE_WD-1:0] keep_out;
   logic                    last_out;
   logic                    ready_out;

   logic                    valid_hdr;
   logic [DATA_WD-1:0]      data_hdr;
   logic [DATA_BYTE_WD-1:0] keep_hdr;
   logic                    ready_hdr;

   modport slave (
      input  valid_cfg, byte_strip_cnt, valid_in, data_in, keep_in, last_in,
             ready_out, ready_hdr,
      output ready_cfg, ready_in, valid_out, data_out, keep_out, last_out,
             valid_hdr, data_hdr, keep_hdr
   );

   modport master (
      output valid_cfg, byte_strip_cnt, valid_in, data_in, keep_in, last_in,
             ready_out, ready_hdr,
      input  ready_cfg, ready_in, valid_out, data_out, keep_out, last_out,
             valid_hdr, data_hdr, keep_hdr
   );
endinterface

// File: rtl/axi_stream_extract_header.sv
// rtl/axi_stream_extract_header.sv - strips an H-byte header off each packet and realigns the payload
module axi_stream_extract_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input logic clk,
   input logic rst,
   axi_stream_extract_header_if.slave bus
);
   localparam int CW = BYTE_CNT_WD + 1;
   localparam int N  = DATA_BYTE_WD;
   localparam logic [CW:0] NB = (CW + 1)'(DATA_BYTE_WD);

   typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;
   state_t state, state_nx;

   logic [CW-1:0]      h_bytes, r_bytes, h_nx, r_nx;
   logic [DATA_WD-1:0] residue, residue_nx;
   logic [N-1:0]       flush_keep, flush_keep_nx;

   logic               out_valid, out_valid_nx, out_last, out_last_nx;
   logic [DATA_WD-1:0] out_data, out_data_nx;
   logic [N-1:0]       out_keep, out_keep_nx;
   logic               hdr_valid, hdr_valid_nx;
   logic [DATA_WD-1:0] hdr_data, hdr_data_nx;
   logic [N-1:0]       hdr_keep, hdr_keep_nx;

   logic               pay_free, rdy_cfg, rdy_in, cfg_fire, in_fire;
   logic [DATA_WD-1:0] din;
   logic [CW-1:0]      k_cnt;
   logic [CW:0]        span;
   logic [CW+2:0]      h_sh, r_sh;

   function automatic logic [N-1:0] keep_top(input logic [CW:0] n);
      return ~({N{1'b1}} >> n);
   endfunction

   assign pay_free = !out_valid || bus.ready_out;
   assign rdy_cfg  = !rst && (state == IDLE);
   assign rdy_in   = !rst && (((state == FIRST) && !hdr_valid && pay_free) ||
                              ((state == BODY) && pay_free));
   assign cfg_fire = bus.valid_cfg && rdy_cfg;
   assign in_fire  = bus.valid_in && rdy_in;
   assign h_sh     = {h_bytes, 3'b000};
   assign r_sh     = {r_bytes, 3'b000};
   assign span     = {1'b0, r_bytes} + {1'b0, k_cnt};

   // Disabled lanes are zeroed on entry so every output lane they reach stays zero.
   always_comb begin
      din   = '0;
      k_cnt = '0;
      for (int i = 0; i < N; i++) begin
         din[i*8 +: 8] = bus.data_in[i*8 +: 8] & {8{bus.keep_in[i]}};
         k_cnt         = k_cnt + CW'(bus.keep_in[i]);
      end
   end

   always_comb begin
      state_nx      = state;
      h_nx          = h_bytes;
      r_nx          = r_bytes;
      residue_nx    = residue;
      flush_keep_nx = flush_keep;
      out_valid_nx  = out_valid && !bus.ready_out;
      out_data_nx   = out_data;
      out_keep_nx   = out_keep;
      out_last_nx   = out_last;
      hdr_valid_nx  = hdr_valid && !bus.ready_hdr;
      hdr_data_nx   = hdr_data;
      hdr_keep_nx   = hdr_keep;
      case (state)
         IDLE: begin
            if (cfg_fire) begin
               h_nx     = {1'b0, bus.byte_strip_cnt} + CW'(1);
               r_nx     = CW'(DATA_BYTE_WD) - h_nx;
               state_nx = FIRST;
            end
         end
         FIRST: begin
            if (in_fire) begin
               hdr_valid_nx = 1'b1;
               hdr_data_nx  = din >> r_sh;
               hdr_keep_nx  = ~({N{1'b1}} << h_bytes);
               residue_nx   = din & ~({DATA_WD{1'b1}} << r_sh);
               if (bus.last_in) begin
                  if (k_cnt > h_bytes) begin
                     out_valid_nx = 1'b1;
                     out_data_nx  = din << h_sh;
                     out_keep_nx  = bus.keep_in << h_bytes;
                     out_last_nx  = 1'b1;
                  end
                  state_nx = IDLE;
               end else begin
                  state_nx = BODY;
               end
            end
         end
         BODY: begin
            if (in_fire) begin
               out_valid_nx = 1'b1;
               out_data_nx  = (residue << h_sh) | (din >> r_sh);
               out_keep_nx  = '1;
               out_last_nx  = 1'b0;
               residue_nx   = din & ~({DATA_WD{1'b1}} << r_sh);
               if (bus.last_in && (span <= NB)) begin
                  out_keep_nx = keep_top(span);
                  out_last_nx = 1'b1;
                  state_nx    = IDLE;
               end else if (bus.last_in) begin
                  // Leftover K-H bytes do not fit this beat; they go out alone from FLUSH.
                  flush_keep_nx = keep_top(span - NB);
                  state_nx      = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (pay_free) begin
               out_valid_nx = 1'b1;
               out_data_nx  = residue << h_sh;
               out_keep_nx  = flush_keep;
               out_last_nx  = 1'b1;
               state_nx     = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         h_bytes    <= '0;
         r_bytes    <= '0;
         residue    <= '0;
         flush_keep <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
         hdr_valid  <= 1'b0;
         hdr_data   <= '0;
         hdr_keep   <= '0;
      end else begin
         state      <= state_nx;
         h_bytes    <= h_nx;
         r_bytes    <= r_nx;
         residue    <= residue_nx;
         flush_keep <= flush_keep_nx;
         out_valid  <= out_valid_nx;
         out_data   <= out_data_nx;
         out_keep   <= out_keep_nx;
         out_last   <= out_last_nx;
         hdr_valid  <= hdr_valid_nx;
         hdr_data   <= hdr_data_nx;
         hdr_keep   <= hdr_keep_nx;
      end
   end

   assign bus.ready_cfg = rdy_cfg;
   assign bus.ready_in  = rdy_in;
   assign bus.valid_out = out_valid;
   assign bus.data_out  = out_data;
   assign bus.keep_out  = out_keep;
   assign bus.last_out  = out_last;
   assign bus.valid_hdr = hdr_valid;
   assign bus.data_hdr  = hdr_data;
   assign bus.keep_hdr  = hdr_keep;
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb/tb_axi_stream_extract_header.sv - scoreboard bench for axi_stream_extract_header
module tb_axi_stream_extract_header;
   localparam int N = 4;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   out_mode = 0;
   int   hdr_mode = 0;
   beat_t exp_pay[$];
   beat_t exp_hdr[$];

   axi_stream_extract_header_if bus ();

   axi_stream_extract_header dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Sink-side ready generators: 0 = always ready, 1 = random, 2 = held low.
   initial forever begin
      @(posedge clk);
      #1;
      bus.ready_out = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ready_hdr = (hdr_mode == 0) ? 1'b1 : (hdr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // Monitor: compares handshaken beats against the scoreboard and checks stall stability.
   initial begin
      logic        pay_hold, hdr_hold;
      logic [36:0] pay_prev, hdr_prev;
      beat_t       e;
      pay_hold = 1'b0;
      hdr_hold = 1'b0;
      pay_prev = '0;
      hdr_prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pay_hold = 1'b0;
            hdr_hold = 1'b0;
         end else begin
            if (pay_hold) begin
               check("out_stall_valid", 64'(bus.valid_out), 64'd1);
               check("out_stall_beat", 64'({bus.last_out, bus.keep_out, bus.data_out}), 64'(pay_prev));
            end
            if (hdr_hold) begin
               check("hdr_stall_valid", 64'(bus.valid_hdr), 64'd1);
               check("hdr_stall_beat", 64'({1'b0, bus.keep_hdr, bus.data_hdr}), 64'(hdr_prev));
            end
            if (bus.valid_out && bus.ready_out) begin
               if (exp_pay.size() == 0) begin
                  check("out_unexpected", 64'({bus.last_out, bus.keep_out, bus.data_out}), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  e = exp_pay.pop_front();
                  check("out_beat", 64'({bus.last_out, bus.keep_out, bus.data_out}), 64'({e.l, e.k, e.d}));
               end
            end
            if (bus.valid_hdr && bus.ready_hdr) begin
               if (exp_hdr.size() == 0) begin
                  check("hdr_unexpected", 64'({bus.keep_hdr, bus.data_hdr}), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  e = exp_hdr.pop_front();
                  check("hdr_beat", 64'({bus.keep_hdr, bus.data_hdr}), 64'({e.k, e.d}));
               end
            end
            pay_hold = bus.valid_out && !bus.ready_out;
            pay_prev = {bus.last_out, bus.keep_out, bus.data_out};
            hdr_hold = bus.valid_hdr && !bus.ready_hdr;
            hdr_prev = {1'b0, bus.keep_hdr, bus.data_hdr};
         end
      end
   end

   // Waits for ready_cfg (sel=0) or ready_in (sel=1); the transfer completes on the next edge.
   task automatic wait_hs(input int sel, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if ((sel == 0) ? bus.ready_cfg : bus.ready_in) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check((sel == 0) ? "cfg_timeout" : "in_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Reference: first H bytes form the header (LSB-aligned), the rest are repacked N per beat.
   task automatic model_packet(input int cnt, input logic [7:0] pk[$]);
      beat_t b;
      int    h, len;
      h   = cnt + 1;
      len = pk.size();
      b.d = '0;
      b.k = '0;
      b.l = 1'b0;
      for (int j = 0; j < h; j++) begin
         b.k[j] = 1'b1;
         if (j < len) b.d[(h-1-j)*8 +: 8] = pk[j];
      end
      exp_hdr.push_back(b);
      for (int p = h; p < len; p += N) begin
         b.d = '0;
         b.k = '0;
         b.l = (p + N >= len);
         for (int i = 0; i < N; i++) begin
            if (p + i < len) begin
               b.d[(N-1-i)*8 +: 8] = pk[p+i];
               b.k[N-1-i] = 1'b1;
            end
         end
         exp_pay.push_back(b);
      end
   endtask

   // max_beats < 0 sends the whole packet; stall_chk verifies FIRST is blocked by a pending header.
   task automatic drive_packet(input int cnt, input logic [7:0] pk[$], input int max_beats, input bit stall_chk);
      int len, nb;
      bit ok;
      len = pk.size();
      nb  = (len + N - 1) / N;
      model_packet(cnt, pk);
      bus.valid_cfg      = 1'b1;
      bus.byte_strip_cnt = 2'(cnt);
      wait_hs(0, ok);
      bus.valid_cfg = 1'b0;
      for (int b = 0; b < nb && (max_beats < 0 || b < max_beats); b++) begin
         bus.data_in = $urandom;
         bus.keep_in = '0;
         for (int i = 0; i < N; i++) begin
            if (b * N + i < len) begin
               bus.data_in[(N-1-i)*8 +: 8] = pk[b*N+i];
               bus.keep_in[N-1-i] = 1'b1;
            end
         end
         bus.last_in  = (b == nb - 1);
         bus.valid_in = 1'b1;
         if (stall_chk && b == 0) begin
            repeat (6) begin
               @(negedge clk);
               check("first_blocked_by_hdr", 64'(bus.ready_in), 64'd0);
            end
            hdr_mode = 0;
         end
         wait_hs(1, ok);
         bus.valid_in = 1'b0;
      end
   endtask

   task automatic make_seq(input int len, input int start, output logic [7:0] pk[$]);
      pk = {};
      for (int i = 0; i < len; i++) pk.push_back(8'(start + i));
   endtask

   task automatic make_rand(input int len, output logic [7:0] pk[$]);
      pk = {};
      for (int i = 0; i < len; i++) pk.push_back(8'($urandom));
   endtask

   initial begin
      logic [7:0] pk[$];
      bit         drained;
      bus.valid_cfg      = 1'b0;
      bus.byte_strip_cnt = '0;
      bus.valid_in       = 1'b0;
      bus.data_in        = '0;
      bus.keep_in        = '0;
      bus.last_in        = 1'b0;
      bus.ready_out      = 1'b1;
      bus.ready_hdr      = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_valid_out", 64'(bus.valid_out), 64'd0);
      check("rst_valid_hdr", 64'(bus.valid_hdr), 64'd0);
      check("rst_ready_cfg", 64'(bus.ready_cfg), 64'd0);
      check("rst_ready_in", 64'(bus.ready_in), 64'd0);
      check("rst_outputs", 64'({bus.last_out, bus.keep_out, bus.data_out}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready_cfg", 64'(bus.ready_cfg), 64'd1);
      @(posedge clk);
      #1;

      // Two-byte header with a short last beat that merges into the final payload beat.
      make_seq(10, 1, pk);
      drive_packet(1, pk, -1, 1'b0);
      // One-byte header whose leftovers spill into a FLUSH beat.
      make_seq(7, 1, pk);
      drive_packet(0, pk, -1, 1'b0);
      // Whole-beat header, single-beat packet: header only, back to IDLE quickly.
      pk = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      drive_packet(3, pk, -1, 1'b0);
      @(negedge clk);
      check("ready_cfg_after_single", 64'(bus.ready_cfg), 64'd1);
      @(posedge clk);
      #1;

      // Pass-through with stalling payload sink.
      out_mode = 1;
      make_rand(20, pk);
      drive_packet(3, pk, -1, 1'b0);

      // Header sink held off: the next packet's first beat must wait.
      out_mode = 0;
      hdr_mode = 2;
      make_rand(8, pk);
      drive_packet(1, pk, -1, 1'b0);
      make_rand(9, pk);
      drive_packet(2, pk, -1, 1'b1);

      // Reset in the middle of a packet body.
      make_rand(14, pk);
      drive_packet(0, pk, 2, 1'b0);
      rst = 1'b1;
      exp_pay.delete();
      exp_hdr.delete();
      @(negedge clk);
      check("midrst_ready_cfg", 64'(bus.ready_cfg), 64'd0);
      check("midrst_ready_in", 64'(bus.ready_in), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_valid_out", 64'(bus.valid_out), 64'd0);
      check("midrst_valid_hdr", 64'(bus.valid_hdr), 64'd0);
      check("midrst_outputs", 64'({bus.last_out, bus.keep_out, bus.data_out, bus.keep_hdr}), 64'd0);
      check("midrst_ready_cfg_back", 64'(bus.ready_cfg), 64'd1);
      @(posedge clk);
      #1;
      make_rand(11, pk);
      drive_packet(2, pk, -1, 1'b0);

      // Random packets with random backpressure on both sinks.
      out_mode = 1;
      hdr_mode = 1;
      for (int p = 0; p < 60; p++) begin
         make_rand($urandom_range(1, 17), pk);
         drive_packet($urandom_range(0, 3), pk, -1, 1'b0);
      end

      out_mode = 0;
      hdr_mode = 0;
      drained = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (exp_pay.size() == 0 && exp_hdr.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge clk);
      check("drain_complete", 64'(drained), 64'd1);
      check("pay_queue_empty", 64'(exp_pay.size()), 64'd0);
      check("hdr_queue_empty", 64'(exp_hdr.size()), 64'd0);
      check("final_valid_out", 64'(bus.valid_out), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
